io_config_loader: RTL and testbench
===================================

# io_config_loader

Serial configuration loader that produces the `c` control vector for a `data_io_block` instance. It accepts a bit-serial configuration frame over a valid/ready handshake into a shadow register and checks the frame for length errors and tri-state bus contention. Only a clean frame is committed atomically to `c`, so the I/O transmission gates never see a partial or conflicting configuration. It sits between the chip-level configuration chain and each I/O block.

## Interface
- `W`, 6, routing data bus width; must be a multiple of `WW`
- `WW`, 3, external port width
- `EXTDATAIN`, 2, number of external input ports
- `EXTDATAOUT`, 3, number of external output ports
- `CW` (localparam), `W*(EXTDATAIN+EXTDATAOUT)` (30 at defaults), config vector width

Ports:
- `clk` in 1: single clock, all state on rising edge
- `reset` in 1: synchronous, active-high
- `cfg_valid` in 1: `cfg_bit` and `cfg_last` are valid
- `cfg_bit` in 1: serial config data
- `cfg_last` in 1: marks the final bit of a frame
- `cfg_ready` out 1: loader accepts a bit this cycle
- `c` out CW: committed gate enables, connects to `data_io_block.c`
- `cfg_done` out 1: one-cycle pulse when a frame is committed
- `cfg_error` out 1: sticky; set on a rejected frame
- `cfg_err_code` out 2: 00 none, 01 length, 10 input contention, 11 output contention

## Operation
- States: IDLE, SHIFT, CHECK.
- A bit is accepted on a cycle when `cfg_valid && cfg_ready`. `cfg_ready` is 1 in IDLE and SHIFT and 0 in CHECK.
- Frame bit k (k=0 first) is written to `shadow[k]`. A 5-bit counter (`$clog2(CW+1)`) tracks accepted bits.
- IDLE: the first accepted bit clears `cfg_error` and `cfg_err_code` and goes to SHIFT, or straight to CHECK if `cfg_last`=1. A 1-bit frame is a length error.
- SHIFT: each accepted bit increments the count. On an accepted bit with `cfg_last`=1, go to CHECK.
- Length rule: the frame length must equal CW exactly.
  - If `cfg_last` arrives with count != CW-1, the frame fails with code 01.
  - If bit CW-1 is accepted without `cfg_last`, go to CHECK flagged with code 01. The loader does not wait for more bits.
- CHECK, evaluated combinationally on the shadow register, with priority length > input > output:
  - Input contention: for any j in 0..W-1, more than one i in 0..EXTDATAIN-1 has `shadow[j+i*W]`=1.
  - Output contention: for any i and m in 0..WW-1, more than one j with j%WW==m has `shadow[j+i*W+EXTDATAIN*W]`=1.
- Leaving CHECK always returns to IDLE and clears the counter.
  - Pass: `c <= shadow`, `cfg_done <= 1`.
  - Fail: `c` unchanged, `cfg_error <= 1`, `cfg_err_code` set.
- `c` changes only on a committed frame or on reset. It never reflects a partially shifted frame.
- Reset values: state IDLE, counter 0, shadow 0, `c` all 0 (all gates off), `cfg_done` 0, `cfg_error` 0, `cfg_err_code` 00. `cfg_ready` is 1 on the first cycle after reset.
- Reset mid-frame or in CHECK: the frame is discarded, `c` is forced to 0, and no `cfg_done` is issued.
- `cfg_valid` during CHECK is ignored, since `cfg_ready`=0. The upstream source must hold the bit.

## Timing
- Throughput: one bit per cycle. A full frame takes CW accept cycles.
- If the last bit is accepted in cycle T:
  - CHECK occupies cycle T+1.
  - `c`, `cfg_done`, `cfg_error` and `cfg_err_code` are registered and visible in cycle T+2.
  - `cfg_ready` is low only during T+1.
- Back-to-back frames: a new first bit can be accepted in cycle T+2. Minimum frame period is CW+1 cycles.
- `cfg_done` is high for exactly one cycle per committed frame.
- `cfg_error` stays high until the first bit of the next frame is accepted.
- `cfg_ready` is a function of state only, with no combinational path from `cfg_valid`.

## Test plan
- **Reset:** assert `reset` 2 cycles, then release -> `c`=0, `cfg_ready`=1, `cfg_done`=0, `cfg_error`=0, code 00.
- **Clean frame:** 30 bits with only `shadow[0]` and `shadow[6+... ]`-free pattern, i.e. only bit 0 (in0→data0) and bit 12 (data0→out0) set, `cfg_last` on bit 29, `cfg_valid` held high -> `c`=30'h0000_1001 exactly 2 cycles after the last bit; `cfg_done` pulses once; `cfg_ready` low for 1 cycle.
- **Input contention:** set bits 0 and 6 (`data[0]` driven by in0 and in1) -> `cfg_error`=1, code 10, `c` keeps its previous value.
- **Output contention:** set bits 12 and 15 (`data[0]` and `data[3]` both drive out0 bit 0) -> code 11, no `cfg_done`. Then a clean frame -> `cfg_error` clears on its first bit and the frame commits.
- **Length errors:**
  - `cfg_last` on bit 9 -> code 01.
  - 30 bits with no `cfg_last` -> code 01 after bit 29, and the following bit is treated as a new frame.
- **Reset mid-frame and stall:** reset after 15 bits -> `c`=0, counter restarts. Drop `cfg_valid` randomly during a clean frame -> the same `c` as with no gaps.

Source files
------------

// File: rtl/io_config_loader.sv
// Bit-serial configuration loader for a data_io_block: shifts a frame into a shadow
// register, screens it for length and bus-contention errors, and commits clean frames to c.
module io_config_loader #(
  parameter int W          = 6,
  parameter int WW         = 3,
  parameter int EXTDATAIN  = 2,
  parameter int EXTDATAOUT = 3,
  localparam int CW        = W * (EXTDATAIN + EXTDATAOUT)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          cfg_valid,
  input  logic          cfg_bit,
  input  logic          cfg_last,
  output logic          cfg_ready,
  output logic [CW-1:0] c,
  output logic          cfg_done,
  output logic          cfg_error,
  output logic [1:0]    cfg_err_code
);

  localparam int CNT_W = $clog2(CW + 1);
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(CW - 1);

  localparam logic [1:0] ERR_NONE    = 2'b00;
  localparam logic [1:0] ERR_LENGTH  = 2'b01;
  localparam logic [1:0] ERR_IN_CON  = 2'b10;
  localparam logic [1:0] ERR_OUT_CON = 2'b11;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    CHECK = 2'd2
  } state_t;

  state_t           state, state_next;
  logic [CNT_W-1:0] cnt;
  logic [CW-1:0]    shadow;
  logic             len_err;
  logic             accept;
  logic             frame_end;
  logic             in_cont, out_cont;
  logic             in_seen, out_seen;

  assign cfg_ready = (state != CHECK);
  assign accept    = cfg_valid && cfg_ready;
  // A frame ends on cfg_last or when the shadow is full, whichever comes first.
  assign frame_end = accept && (cfg_last || (cnt == LAST_IDX));

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE, SHIFT: begin
        if (frame_end)   state_next = CHECK;
        else if (accept) state_next = SHIFT;
      end
      CHECK:   state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    in_cont = 1'b0;
    in_seen = 1'b0;
    for (int j = 0; j < W; j++) begin
      in_seen = 1'b0;
      for (int i = 0; i < EXTDATAIN; i++) begin
        if (shadow[j + i*W]) begin
          if (in_seen) in_cont = 1'b1;
          in_seen = 1'b1;
        end
      end
    end
  end

  // Data lines that share a residue mod WW land on the same output port bit.
  always_comb begin
    out_cont = 1'b0;
    out_seen = 1'b0;
    for (int i = 0; i < EXTDATAOUT; i++) begin
      for (int m = 0; m < WW; m++) begin
        out_seen = 1'b0;
        for (int k = 0; k < W/WW; k++) begin
          if (shadow[m + k*WW + i*W + EXTDATAIN*W]) begin
            if (out_seen) out_cont = 1'b1;
            out_seen = 1'b1;
          end
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt          <= '0;
      shadow       <= '0;
      len_err      <= 1'b0;
      c            <= '0;
      cfg_done     <= 1'b0;
      cfg_error    <= 1'b0;
      cfg_err_code <= ERR_NONE;
    end else begin
      cfg_done <= 1'b0;
      case (state)
        IDLE, SHIFT: begin
          if (accept) begin
            shadow[cnt] <= cfg_bit;
            cnt         <= cnt + 1'b1;
            if (state == IDLE) begin
              cfg_error    <= 1'b0;
              cfg_err_code <= ERR_NONE;
            end
            if (frame_end) len_err <= !(cfg_last && (cnt == LAST_IDX));
          end
        end
        CHECK: begin
          cnt <= '0;
          if (len_err) begin
            cfg_error    <= 1'b1;
            cfg_err_code <= ERR_LENGTH;
          end else if (in_cont) begin
            cfg_error    <= 1'b1;
            cfg_err_code <= ERR_IN_CON;
          end else if (out_cont) begin
            cfg_error    <= 1'b1;
            cfg_err_code <= ERR_OUT_CON;
          end else begin
            c        <= shadow;
            cfg_done <= 1'b1;
          end
        end
        default: cnt <= '0;
      endcase
    end
  end

endmodule

// File: tb/tb_io_config_loader.sv
// Scoreboard bench for io_config_loader: driver pushes hand-computed frame results,
// a negedge monitor pops them on the cycle after CHECK and compares.
module tb_io_config_loader;

  localparam int CW = 30;

  logic          clk = 1'b0;
  logic          reset;
  logic          cfg_valid, cfg_bit, cfg_last;
  logic          cfg_ready;
  logic [CW-1:0] c;
  logic          cfg_done, cfg_error;
  logic [1:0]    cfg_err_code;

  io_config_loader dut (
    .clk          (clk),
    .reset        (reset),
    .cfg_valid    (cfg_valid),
    .cfg_bit      (cfg_bit),
    .cfg_last     (cfg_last),
    .cfg_ready    (cfg_ready),
    .c            (c),
    .cfg_done     (cfg_done),
    .cfg_error    (cfg_error),
    .cfg_err_code (cfg_err_code)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [CW-1:0] c;
    logic          done;
    logic          err;
    logic [1:0]    code;
    int            cyc;
  } exp_t;

  exp_t          sb[$];
  int            cyc = 0;
  int            n_total = 0;
  int            n_pass = 0;
  logic [CW-1:0] c_model = '0;
  logic          prev_ready = 1'b1;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (reset !== 1'b0) begin
      prev_ready = 1'b1;
    end else begin
      if (prev_ready === 1'b0) begin
        if (sb.size() == 0) begin
          check("unexpected_result", 64'(cfg_done), 64'(1'b0));
        end else begin
          e = sb.pop_front();
          check("result_c",     64'(c),            64'(e.c));
          check("result_done",  64'(cfg_done),     64'(e.done));
          check("result_error", 64'(cfg_error),    64'(e.err));
          check("result_code",  64'(cfg_err_code), 64'(e.code));
          check("result_cycle", 64'(cyc),          64'(e.cyc));
          check("ready_back",   64'(cfg_ready),    64'(1'b1));
        end
      end else begin
        check("no_stray_done", 64'(cfg_done), 64'(1'b0));
      end
      prev_ready = cfg_ready;
    end
  end

  task automatic send_frame(input logic [CW-1:0] bits, input int len, input bit with_last,
                            input bit gaps, input bit chk_clear, output int t_last);
    t_last = 0;
    for (int k = 0; k < len; k++) begin
      if (gaps) begin
        int g;
        g = $urandom_range(0, 2);
        cfg_valid = 1'b0;
        repeat (g) @(negedge clk);
      end
      cfg_valid = 1'b1;
      cfg_bit   = bits[k];
      cfg_last  = with_last && (k == len - 1);
      begin
        int w;
        w = 0;
        while (cfg_ready !== 1'b1 && w < 10) begin
          @(negedge clk);
          w++;
        end
        if (w >= 10) check("ready_timeout", 64'(cfg_ready), 64'(1'b1));
      end
      t_last = cyc;
      @(negedge clk);
      if (chk_clear && k == 0) begin
        check("error_cleared", 64'(cfg_error),    64'(1'b0));
        check("code_cleared",  64'(cfg_err_code), 64'(2'b00));
      end
    end
    cfg_valid = 1'b0;
    cfg_last  = 1'b0;
  endtask

  task automatic expect_result(input logic [CW-1:0] bits, input logic [1:0] code, input int t_last);
    exp_t e;
    if (code == 2'b00) c_model = bits;
    e.c    = c_model;
    e.done = (code == 2'b00);
    e.err  = (code != 2'b00);
    e.code = code;
    e.cyc  = t_last + 2;
    sb.push_back(e);
  endtask

  task automatic frame(input logic [CW-1:0] bits, input int len, input bit with_last,
                       input bit gaps, input bit chk_clear, input logic [1:0] code);
    int t;
    send_frame(bits, len, with_last, gaps, chk_clear, t);
    expect_result(bits, code, t);
  endtask

  localparam logic [CW-1:0] F_CLEAN_A = 30'h0000_1001; // in0->d0, d0->out0.0
  localparam logic [CW-1:0] F_CLEAN_B = 30'h0010_2080; // in1->d1, d1->out0.1, d2->out1.2
  localparam logic [CW-1:0] F_IN_CON  = 30'h0000_0041; // d0 driven by in0 and in1
  localparam logic [CW-1:0] F_OUT_CON = 30'h0000_9000; // d0 and d3 both on out0.0
  localparam logic [CW-1:0] F_BOTH    = 30'h0000_9041;
  localparam logic [CW-1:0] F_ONES    = 30'h3FFF_FFFF;

  initial begin
    int t;
    reset     = 1'b1;
    cfg_valid = 1'b0;
    cfg_bit   = 1'b0;
    cfg_last  = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check("rst_c",     64'(c),            64'(0));
    check("rst_ready", 64'(cfg_ready),    64'(1'b1));
    check("rst_done",  64'(cfg_done),     64'(1'b0));
    check("rst_error", 64'(cfg_error),    64'(1'b0));
    check("rst_code",  64'(cfg_err_code), 64'(2'b00));

    frame(F_CLEAN_A, CW, 1'b1, 1'b0, 1'b0, 2'b00);
    frame(F_IN_CON,  CW, 1'b1, 1'b0, 1'b0, 2'b10);
    frame(F_OUT_CON, CW, 1'b1, 1'b0, 1'b0, 2'b11);
    frame(F_CLEAN_B, CW, 1'b1, 1'b0, 1'b1, 2'b00);
    frame(F_BOTH,    CW, 1'b1, 1'b0, 1'b0, 2'b10);
    frame(F_ONES,    10, 1'b1, 1'b0, 1'b0, 2'b01);
    frame(F_ONES,    1,  1'b1, 1'b0, 1'b1, 2'b01);
    frame(F_CLEAN_A, CW, 1'b0, 1'b0, 1'b1, 2'b01);
    frame(F_CLEAN_A, CW, 1'b1, 1'b0, 1'b1, 2'b00);

    send_frame(F_CLEAN_B, 15, 1'b0, 1'b0, 1'b0, t);
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    c_model = '0;
    @(negedge clk);
    check("midrst_c",     64'(c),         64'(c_model));
    check("midrst_ready", 64'(cfg_ready), 64'(1'b1));
    check("midrst_error", 64'(cfg_error), 64'(1'b0));
    check("midrst_done",  64'(cfg_done),  64'(1'b0));

    frame(F_CLEAN_B, CW, 1'b1, 1'b1, 1'b0, 2'b00);
    frame(F_CLEAN_A, CW, 1'b1, 1'b0, 1'b0, 2'b00);

    begin
      int w;
      w = 0;
      while (sb.size() != 0 && w < 100) begin
        @(negedge clk);
        w++;
      end
      check("queue_drained", 64'(sb.size()), 64'(0));
    end
    repeat (3) @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
